// File: rtl/uart_rx_frame_assembler.sv
// UART receive frame assembler: gathers NUM_BYTES bytes into a shadow
// register and publishes them to frame_out with a one-cycle done pulse.
// Partial frames are dropped after an inter-byte timeout or on clear.
// Optional trailing XOR checksum byte: define UART_RX_FRAME_CHECKSUM_EN.
module uart_rx_frame_assembler #(
    parameter int unsigned NUM_BYTES      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            new_data,
    input  logic [7:0]                      data,
    input  logic                            clear,
    output logic [8*NUM_BYTES-1:0]          frame_out,
    output logic                            done,
    output logic                            busy,
    output logic [$clog2(NUM_BYTES+2)-1:0]  byte_count,
    output logic                            timeout_err,
    output logic                            chk_err
);

`ifdef UART_RX_FRAME_CHECKSUM_EN
    localparam int unsigned L = NUM_BYTES + 1;
`else
    localparam int unsigned L = NUM_BYTES;
`endif
    localparam int unsigned CW = $clog2(NUM_BYTES + 2);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   new_data_q;
    logic [8*L-1:0]         shadow_q, shadow_d;
    logic [8*NUM_BYTES-1:0] frame_q, frame_d;
    logic [CW-1:0]          count_q, count_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   done_q, done_d;
    logic                   terr_q, terr_d;
    logic                   accept;
    logic                   chk_ok;
`ifdef UART_RX_FRAME_CHECKSUM_EN
    logic                   cerr_q, cerr_d;
    logic [7:0]             xsum;

    // XOR of the payload bytes, compared against the trailing checksum byte
    always_comb begin
        xsum = '0;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            xsum = xsum ^ shadow_q[i*8 +: 8];
        end
    end
    assign chk_ok  = (xsum == shadow_q[8*L-1 -: 8]);
    assign chk_err = cerr_q;
`else
    assign chk_ok  = 1'b1;
    assign chk_err = 1'b0;
`endif

    assign accept = new_data & ~new_data_q;

    // Next-state, shadow capture, timeout and output pulse logic
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        count_d  = count_q;
        tmo_d    = tmo_q;
        done_d   = 1'b0;
        terr_d   = 1'b0;
`ifdef UART_RX_FRAME_CHECKSUM_EN
        cerr_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                tmo_d   = '0;
                count_d = '0;
                if (!clear && accept) begin
                    shadow_d[7:0] = data;
                    count_d       = CW'(1);
                    state_d       = (L == 1) ? COMMIT : RECV;
                end
            end
            RECV: begin
                if (clear) begin
                    state_d = IDLE;
                    count_d = '0;
                    tmo_d   = '0;
                end else if (accept) begin
                    shadow_d[count_q*8 +: 8] = data;
                    count_d = count_q + CW'(1);
                    tmo_d   = '0;
                    if (count_q == CW'(L - 1)) state_d = COMMIT;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d  = IDLE;
                        shadow_d = '0;
                        count_d  = '0;
                        tmo_d    = '0;
                        terr_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            COMMIT: begin
                // clear is ignored here; it takes effect in IDLE next cycle
                state_d = IDLE;
                count_d = '0;
                tmo_d   = '0;
                if (chk_ok) begin
                    frame_d = shadow_q[8*NUM_BYTES-1:0];
                    done_d  = 1'b1;
                end else begin
`ifdef UART_RX_FRAME_CHECKSUM_EN
                    cerr_d  = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-high reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            new_data_q <= 1'b1;
            shadow_q   <= '0;
            frame_q    <= '0;
            count_q    <= '0;
            tmo_q      <= '0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
`ifdef UART_RX_FRAME_CHECKSUM_EN
            cerr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            new_data_q <= new_data;
            shadow_q   <= shadow_d;
            frame_q    <= frame_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            terr_q     <= terr_d;
`ifdef UART_RX_FRAME_CHECKSUM_EN
            cerr_q     <= cerr_d;
`endif
        end
    end

    assign frame_out   = frame_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign byte_count  = count_q;
    assign busy        = (state_q == RECV);

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Directed self-checking bench for uart_rx_frame_assembler.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_frame_assembler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          total = 0;
    int          passed = 0;

    // Instance A: NUM_BYTES=2, TIMEOUT_CYCLES=100
    logic        nd = 1'b0;
    logic [7:0]  dat = 8'h00;
    logic        clr = 1'b0;
    logic [15:0] frame;
    logic        done, busy, terr, cerr;
    logic [1:0]  cnt;

    // Instance B: NUM_BYTES=4, timeout disabled
    logic        nd4 = 1'b0;
    logic [7:0]  dat4 = 8'h00;
    logic        clr4 = 1'b0;
    logic [31:0] frame4;
    logic        done4, busy4, terr4, cerr4;
    logic [2:0]  cnt4;

    always #5 clock = ~clock;

    uart_rx_frame_assembler #(.NUM_BYTES(2), .TIMEOUT_CYCLES(100)) dut (
        .clock(clock), .reset(reset), .new_data(nd), .data(dat), .clear(clr),
        .frame_out(frame), .done(done), .busy(busy), .byte_count(cnt),
        .timeout_err(terr), .chk_err(cerr)
    );

    uart_rx_frame_assembler #(.NUM_BYTES(4), .TIMEOUT_CYCLES(0)) dut4 (
        .clock(clock), .reset(reset), .new_data(nd4), .data(dat4), .clear(clr4),
        .frame_out(frame4), .done(done4), .busy(busy4), .byte_count(cnt4),
        .timeout_err(terr4), .chk_err(cerr4)
    );

    // Byte strobe: high for one cycle, returns just after the accepting edge
    task automatic send(input logic [7:0] b);
        dat = b; nd = 1'b1;
        @(negedge clock);
        nd = 1'b0;
    endtask

    task automatic send4(input logic [7:0] b);
        dat4 = b; nd4 = 1'b1;
        @(negedge clock);
        nd4 = 1'b0;
    endtask

    task automatic test_reset;
        nd = 1'b1; dat = 8'h77;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++; if (frame !== 16'h0000) $display("FAIL reset_frame got %h want 0000", frame); else passed++;
        total++; if ({done, busy, terr, cerr} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {done, busy, terr, cerr}); else passed++;
        total++; if (cnt !== 2'd0) $display("FAIL reset_count got %0d want 0", cnt); else passed++;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (cnt !== 2'd0) $display("FAIL held_through_reset_count got %0d want 0", cnt); else passed++;
        nd = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic;
        send(8'hA5);
        total++; if (cnt !== 2'd1) $display("FAIL basic_count1 got %0d want 1", cnt); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else passed++;
        @(negedge clock);
        send(8'h3C);
        total++; if (done !== 1'b0) $display("FAIL basic_done_early got %b want 0", done); else passed++;
        @(negedge clock);
        total++; if (done !== 1'b1) $display("FAIL basic_done got %b want 1", done); else passed++;
        total++; if (frame !== 16'h3CA5) $display("FAIL basic_frame got %h want 3ca5", frame); else passed++;
        total++; if (cnt !== 2'd0) $display("FAIL basic_count_clr got %0d want 0", cnt); else passed++;
        @(negedge clock);
        total++; if ({done, busy} !== 2'b00) $display("FAIL basic_after got done/busy %b want 00", {done, busy}); else passed++;
    endtask

    task automatic test_hold_and_clear;
        dat = 8'h11; nd = 1'b1;
        repeat (10) @(negedge clock);
        total++; if (cnt !== 2'd1) $display("FAIL hold_count got %0d want 1", cnt); else passed++;
        nd = 1'b0;
        clr = 1'b1;
        @(negedge clock);
        clr = 1'b0;
        total++; if ({cnt, busy, done, terr} !== 5'b0) $display("FAIL clear_state got cnt/busy/done/terr %b want 00000", {cnt, busy, done, terr}); else passed++;
        total++; if (frame !== 16'h3CA5) $display("FAIL clear_frame got %h want 3ca5", frame); else passed++;
    endtask

    task automatic test_timeout;
        send(8'h01);
        repeat (99) @(negedge clock);
        total++; if ({terr, cnt} !== 3'b001) $display("FAIL timeout_early got terr/cnt %b want 001", {terr, cnt}); else passed++;
        @(negedge clock);
        total++; if (terr !== 1'b1) $display("FAIL timeout_pulse got %b want 1", terr); else passed++;
        total++; if ({cnt, busy} !== 3'b000) $display("FAIL timeout_state got cnt/busy %b want 000", {cnt, busy}); else passed++;
        total++; if (frame !== 16'h3CA5) $display("FAIL timeout_frame got %h want 3ca5", frame); else passed++;
        @(negedge clock);
        total++; if (terr !== 1'b0) $display("FAIL timeout_width got %b want 0", terr); else passed++;
        send(8'h02);
        @(negedge clock);
        send(8'h03);
        @(negedge clock);
        total++; if ({done, frame} !== {1'b1, 16'h0302}) $display("FAIL timeout_next got done/frame %b/%h want 1/0302", done, frame); else passed++;
    endtask

    task automatic test_byte_beats_timeout;
        send(8'h07);
        repeat (99) @(negedge clock);
        send(8'h08);
        total++; if ({terr, cnt} !== 3'b010) $display("FAIL race_state got terr/cnt %b want 010", {terr, cnt}); else passed++;
        @(negedge clock);
        total++; if ({done, frame} !== {1'b1, 16'h0807}) $display("FAIL race_frame got done/frame %b/%h want 1/0807", done, frame); else passed++;
    endtask

    task automatic test_reset_mid;
        send(8'h99);
        reset = 1'b1;
        #1;
        total++; if ({frame, cnt, busy, done} !== 20'h0) $display("FAIL async_reset got frame/cnt/busy/done %h want 0", {frame, cnt, busy, done}); else passed++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        send(8'h55);
        @(negedge clock);
        send(8'hAA);
        @(negedge clock);
        total++; if ({done, frame} !== {1'b1, 16'hAA55}) $display("FAIL post_reset_frame got done/frame %b/%h want 1/aa55", done, frame); else passed++;
    endtask

    task automatic test_clear_with_byte;
        send(8'h10);
        dat = 8'h20; nd = 1'b1; clr = 1'b1;
        @(negedge clock);
        nd = 1'b0; clr = 1'b0;
        total++; if ({cnt, busy, done} !== 4'b0000) $display("FAIL clear_byte got cnt/busy/done %b want 0000", {cnt, busy, done}); else passed++;
        @(negedge clock);
        total++; if ({done, frame} !== {1'b0, 16'hAA55}) $display("FAIL clear_byte_frame got done/frame %b/%h want 0/aa55", done, frame); else passed++;
    endtask

    task automatic test_clear_in_commit;
        send(8'h21);
        @(negedge clock);
        send(8'h22);
        clr = 1'b1;
        @(negedge clock);
        clr = 1'b0;
        total++; if ({done, frame} !== {1'b1, 16'h2221}) $display("FAIL clear_commit got done/frame %b/%h want 1/2221", done, frame); else passed++;
    endtask

    task automatic test_back_to_back;
        send(8'h01);
        @(negedge clock);
        send(8'h02);
        @(negedge clock);
        total++; if ({done, frame} !== {1'b1, 16'h0201}) $display("FAIL b2b_first got done/frame %b/%h want 1/0201", done, frame); else passed++;
        send(8'h03);
        total++; if ({done, cnt} !== 3'b001) $display("FAIL b2b_start got done/cnt %b want 001", {done, cnt}); else passed++;
        @(negedge clock);
        send(8'h04);
        @(negedge clock);
        total++; if ({done, frame} !== {1'b1, 16'h0403}) $display("FAIL b2b_second got done/frame %b/%h want 1/0403", done, frame); else passed++;
    endtask

`ifdef UART_RX_FRAME_CHECKSUM_EN
    task automatic test_checksum;
        send(8'h12); @(negedge clock);
        send(8'h34); @(negedge clock);
        send(8'h26); @(negedge clock);
        total++; if ({done, cerr, frame} !== {2'b10, 16'h3412}) $display("FAIL chk_good got done/cerr/frame %b%b/%h want 10/3412", done, cerr, frame); else passed++;
        send(8'h12); @(negedge clock);
        send(8'h34); @(negedge clock);
        send(8'h27); @(negedge clock);
        total++; if ({done, cerr, frame} !== {2'b01, 16'h3412}) $display("FAIL chk_bad got done/cerr/frame %b%b/%h want 01/3412", done, cerr, frame); else passed++;
    endtask
`endif

    task automatic test_four_bytes;
        send4(8'hEE); @(negedge clock);
        send4(8'hEF);
        repeat (150) @(negedge clock);
        total++; if ({cnt4, terr4} !== 4'b0100) $display("FAIL nb4_no_timeout got cnt/terr %b want 0100", {cnt4, terr4}); else passed++;
        clr4 = 1'b1;
        @(negedge clock);
        clr4 = 1'b0;
        total++; if ({cnt4, busy4} !== 4'b0000) $display("FAIL nb4_clear got cnt/busy %b want 0000", {cnt4, busy4}); else passed++;
        for (int i = 1; i <= 3; i++) begin
            send4(8'(i));
            total++; if ({done4, cnt4} !== {1'b0, 3'(i)}) $display("FAIL nb4_partial got done/cnt %b want 0/%0d", {done4, cnt4}, i); else passed++;
            @(negedge clock);
            total++; if (done4 !== 1'b0) $display("FAIL nb4_spurious_done got %b want 0", done4); else passed++;
        end
        send4(8'h04);
        @(negedge clock);
        total++; if ({done4, frame4} !== {1'b1, 32'h04030201}) $display("FAIL nb4_frame got done/frame %b/%h want 1/04030201", done4, frame4); else passed++;
        @(negedge clock);
        total++; if ({done4, busy4, cnt4} !== 5'b0) $display("FAIL nb4_after got done/busy/cnt %b want 00000", {done4, busy4, cnt4}); else passed++;
    endtask

    initial begin
        @(negedge clock);
        test_reset;
`ifdef UART_RX_FRAME_CHECKSUM_EN
        test_checksum;
`else
        test_basic;
        test_hold_and_clear;
        test_timeout;
        test_byte_beats_timeout;
        test_reset_mid;
        test_clear_with_byte;
        test_clear_in_commit;
        test_back_to_back;
`endif
        test_four_bytes;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired after %0d of %0d checks passed", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
